// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide engine for the multi-cycle MIPS
//               datapath. It performs a radix-2 shift-add multiply or a
//               restoring divide on unsigned magnitudes over WIDTH cycles,
//               then applies sign correction. The 2*WIDTH result is
//               presented as Lo/Hi halves, and a one-cycle done pulse is
//               raised when the result is ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH          operand width (result is 2*WIDTH, split into Lo/Hi)
// Ports
//   CLK            in   clock, rising edge
//   RST            in   synchronous active-high reset
//   Operand1       in   multiplicand / dividend (rs)
//   Operand2       in   multiplier / divisor (rt)
//   mult_start     in   start a multiply (sampled only in IDLE, wins ties)
//   div_start      in   start a divide (sampled only in IDLE)
//   md_signed      in   1 = MULT/DIV, 0 = MULTU/DIVU
//   Lo_Out         out  product low half or quotient
//   Hi_Out         out  product high half or remainder
//   mult_div_done  out  one-cycle pulse, results valid from this cycle on
//   busy           out  high in every state except IDLE
//   div_by_zero    out  set by the last completed divide with divisor 0
// Configuration
//   MDU_EARLY_OUT_EN  when defined, a multiply with a zero operand or a
//                     divide with a zero divisor skips CALC and goes
//                     straight from IDLE to FIX.
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic             md_signed,
   output logic [WIDTH-1:0] Lo_Out,
   output logic [WIDTH-1:0] Hi_Out,
   output logic             mult_div_done,
   output logic             busy,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]         state;
   logic [1:0]         state_next;

   // Operation context latched at start
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   a_mag;     // multiplicand, or dividend shifting out MSB-first
   logic [WIDTH-1:0]   b_mag;     // multiplier shifting out LSB-first, or divisor
   logic [WIDTH-1:0]   op1_raw;   // untouched Operand1 for the divide-by-zero result
   logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
   logic [CNT_W-1:0]   cnt;

   logic               start;
   logic               early_out;

   // Multiply step
   logic [WIDTH:0]     mul_sum;

   // Divide step
   logic [WIDTH-1:0]   div_shift_lo;
   logic               div_shift_hi;
   logic [WIDTH-1:0]   div_diff;
   logic               div_borrow;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_next;

   // Sign-corrected result
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_lo;
   logic [WIDTH-1:0]   fix_hi;
   logic               fix_dbz;

   assign start = mult_start | div_start;

`ifdef MDU_EARLY_OUT_EN
   always_comb begin
      early_out = 1'b0;
      if (mult_start) begin
         early_out = (Operand1 == '0) || (Operand2 == '0);
      end else if (div_start) begin
         early_out = (Operand2 == '0);
      end
   end
`else
   assign early_out = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = early_out ? FIX : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_next = FIX;
            end
         end
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy          = (state != IDLE);
      mult_div_done = (state == DONE);
   end

   // -------------------------------------------------------------------------
   // Iteration datapath
   // -------------------------------------------------------------------------
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (b_mag[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});

   // The shifted partial remainder is WIDTH+1 bits wide. When its top bit is
   // set it already exceeds any divisor, so the subtraction can be done on the
   // low WIDTH bits and the borrow ignored.
   assign div_shift_hi = acc[2*WIDTH-1];
   assign div_shift_lo = {acc[2*WIDTH-2:WIDTH], a_mag[WIDTH-1]};
   assign {div_borrow, div_diff} = {1'b0, div_shift_lo} - {1'b0, b_mag};
   assign div_ge   = div_shift_hi | ~div_borrow;
   assign rem_next = div_ge ? div_diff : div_shift_lo;

   // -------------------------------------------------------------------------
   // Sign correction / special cases evaluated in FIX
   // -------------------------------------------------------------------------
   always_comb begin
      prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
      quot       = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem        = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo     = prod_fixed[WIDTH-1:0];
      fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
      fix_dbz    = 1'b0;
      if (is_div) begin
         if (b_mag == '0) begin
            fix_lo  = '1;
            fix_hi  = op1_raw;
            fix_dbz = 1'b1;
         end else begin
            fix_lo = quot;
            fix_hi = rem;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         is_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         a_mag       <= '0;
         b_mag       <= '0;
         op1_raw     <= '0;
         acc         <= '0;
         cnt         <= '0;
         Lo_Out      <= '0;
         Hi_Out      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Multiply has priority over a simultaneous divide request
                  is_div  <= ~mult_start;
                  sign_a  <= md_signed & Operand1[WIDTH-1];
                  sign_b  <= md_signed & Operand2[WIDTH-1];
                  a_mag   <= (md_signed & Operand1[WIDTH-1]) ? -Operand1 : Operand1;
                  b_mag   <= (md_signed & Operand2[WIDTH-1]) ? -Operand2 : Operand2;
                  op1_raw <= Operand1;
                  acc     <= '0;
                  cnt     <= CNT_W'(WIDTH-1);
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               if (!is_div) begin
                  // Add-then-shift: carry and high half move right one place,
                  // consumed multiplier bits are replaced by product bits.
                  acc   <= {mul_sum, acc[WIDTH-1:1]};
                  b_mag <= b_mag >> 1;
               end else begin
                  acc   <= {rem_next, acc[WIDTH-2:0], div_ge};
                  a_mag <= a_mag << 1;
               end
            end
            FIX: begin
               Lo_Out      <= fix_lo;
               Hi_Out      <= fix_hi;
               div_by_zero <= fix_dbz;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] Operand1 = '0;
   logic [31:0] Operand2 = '0;
   logic        mult_start = 1'b0;
   logic        div_start = 1'b0;
   logic        md_signed = 1'b0;
   logic [31:0] Lo_Out;
   logic [31:0] Hi_Out;
   logic        mult_div_done;
   logic        busy;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;
   int lat;
   logic busy_at_start;
   logic busy_after_done;

   localparam int FULL_LAT = 33;   // edges from start edge to the done cycle
`ifdef MDU_EARLY_OUT_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = FULL_LAT;
`endif

   mult_div_unit #(.WIDTH(32)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .Operand1      (Operand1),
      .Operand2      (Operand2),
      .mult_start    (mult_start),
      .div_start     (div_start),
      .md_signed     (md_signed),
      .Lo_Out        (Lo_Out),
      .Hi_Out        (Hi_Out),
      .mult_div_done (mult_div_done),
      .busy          (busy),
      .div_by_zero   (div_by_zero)
   );

   always #5 CLK = ~CLK;

   // Launch one operation and wait (bounded) for done. lat = -1 on timeout.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input logic ms, input logic ds, input logic sgn,
                        output int l);
      @(negedge CLK);
      Operand1 = a; Operand2 = b; mult_start = ms; div_start = ds; md_signed = sgn;
      @(posedge CLK);
      #1;
      mult_start = 1'b0; div_start = 1'b0;
      busy_at_start = busy;
      l = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge CLK);
         #1;
         if (mult_div_done) begin
            l = i;
            break;
         end
      end
      @(posedge CLK);
      #1;
      busy_after_done = busy;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({Lo_Out, Hi_Out} !== 64'h0) begin
         errors++; $display("FAIL reset_lohi got %h want 0", {Hi_Out, Lo_Out});
      end
      checks++;
      if ({mult_div_done, busy, div_by_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {mult_div_done, busy, div_by_zero});
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_multu_max();
      do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== FULL_LAT) begin
         errors++; $display("FAIL multu_max_latency got %0d want %0d", lat, FULL_LAT);
      end
      checks++;
      if (busy_at_start !== 1'b1 || busy_after_done !== 1'b0) begin
         errors++; $display("FAIL multu_max_busy got %b%b want 10", busy_at_start, busy_after_done);
      end
      checks++;
      if (Hi_Out !== 32'hFFFFFFFE || Lo_Out !== 32'h00000001) begin
         errors++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", Hi_Out, Lo_Out);
      end
   endtask

   task automatic test_mult_signed();
      do_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 1'b1, lat);
      checks++;
      if (Hi_Out !== 32'hFFFFFFFF || Lo_Out !== 32'hFFFFFFEB || lat !== FULL_LAT) begin
         errors++; $display("FAIL mult_m3x7 got %h_%h lat %0d want ffffffff_ffffffeb lat %0d", Hi_Out, Lo_Out, lat, FULL_LAT);
      end
      do_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 1'b0, lat);
      checks++;
      if (Hi_Out !== 32'h00000006 || Lo_Out !== 32'hFFFFFFEB) begin
         errors++; $display("FAIL multu_m3x7 got %h_%h want 00000006_ffffffeb", Hi_Out, Lo_Out);
      end
   endtask

   task automatic test_div_signed();
      do_op(32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 1'b1, lat);
      checks++;
      if (Lo_Out !== 32'hFFFFFFFD || Hi_Out !== 32'hFFFFFFFF || lat !== FULL_LAT) begin
         errors++; $display("FAIL div_m7d2 got q %h r %h lat %0d want q fffffffd r ffffffff", Lo_Out, Hi_Out, lat);
      end
      checks++;
      if (div_by_zero !== 1'b0) begin
         errors++; $display("FAIL div_m7d2_dbz got %b want 0", div_by_zero);
      end
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, lat);
      checks++;
      if (Lo_Out !== 32'h80000000 || Hi_Out !== 32'h00000000 || div_by_zero !== 1'b0) begin
         errors++; $display("FAIL div_overflow got q %h r %h dbz %b want q 80000000 r 0 dbz 0", Lo_Out, Hi_Out, div_by_zero);
      end
   endtask

   task automatic test_div_by_zero();
      do_op(32'd100, 32'd0, 1'b0, 1'b1, 1'b0, lat);
      checks++;
      if (lat !== DIV0_LAT) begin
         errors++; $display("FAIL div0_latency got %0d want %0d", lat, DIV0_LAT);
      end
      checks++;
      if (Lo_Out !== 32'hFFFFFFFF || Hi_Out !== 32'h00000064) begin
         errors++; $display("FAIL div0_result got q %h r %h want q ffffffff r 00000064", Lo_Out, Hi_Out);
      end
      checks++;
      if (div_by_zero !== 1'b1) begin
         errors++; $display("FAIL div0_flag got %b want 1", div_by_zero);
      end
   endtask

   task automatic test_both_starts();
      do_op(32'd6, 32'd7, 1'b1, 1'b1, 1'b0, lat);
      checks++;
      if (Lo_Out !== 32'd42 || Hi_Out !== 32'd0) begin
         errors++; $display("FAIL both_starts got %h_%h want 0_2a", Hi_Out, Lo_Out);
      end
      checks++;
      if (div_by_zero !== 1'b0) begin
         errors++; $display("FAIL both_starts_dbz got %b want 0", div_by_zero);
      end
   endtask

   task automatic test_abort_reset();
      logic seen;
      @(negedge CLK);
      Operand1 = 32'd5; Operand2 = 32'd7; mult_start = 1'b1; md_signed = 1'b0;
      @(posedge CLK);
      #1;
      mult_start = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      div_start = 1'b1;               // iteration 5: must be ignored
      Operand2 = 32'd0;
      @(negedge CLK);
      div_start = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checks++;
      if (busy !== 1'b1 || Lo_Out !== 32'd42 || Hi_Out !== 32'd0) begin
         errors++; $display("FAIL abort_hold got busy %b %h_%h want busy 1 0_2a", busy, Hi_Out, Lo_Out);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if ({Lo_Out, Hi_Out} !== 64'h0 || {mult_div_done, busy, div_by_zero} !== 3'b000) begin
         errors++; $display("FAIL abort_reset got %h_%h flags %b want 0 flags 000", Hi_Out, Lo_Out, {mult_div_done, busy, div_by_zero});
      end
      @(negedge CLK);
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (mult_div_done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL abort_no_done got activity %b want 0", seen);
      end
      do_op(32'd9, 32'd4, 1'b0, 1'b1, 1'b0, lat);
      checks++;
      if (Lo_Out !== 32'd2 || Hi_Out !== 32'd1 || lat !== FULL_LAT) begin
         errors++; $display("FAIL divu_9d4 got q %h r %h lat %0d want q 2 r 1 lat %0d", Lo_Out, Hi_Out, lat, FULL_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_div_signed();
      test_div_by_zero();
      test_both_starts();
      test_abort_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
